ssd_sum_display: RTL

- Downstream stage of the sign-magnitude I/Q adder. Captures the 8-bit sum magnitude plus a sign flag.
- Converts the magnitude to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display: digit 3 = sign, digits 2..0 = hundreds/tens/ones.

---
 rtl/ssd_pkg.sv | 14 +
 rtl/bin2bcd_seq.sv | 59 +++++
 rtl/ssd_sum_display.sv | 68 ++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared FSM state, BCD digit type and active-low segment patterns for the sum display.
package ssd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic logic [6:0] seg_decode(input bcd_t d);
    return (d > 4'd9) ? SEG_BLANK : SEG_DIGIT[d];
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter for an 8-bit magnitude, with captured sign and busy flag.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bin,
  input  logic       neg,
  output logic       busy,
  output logic       done,
  output logic       neg_q,
  output bcd_t       hund,
  output bcd_t       tens,
  output bcd_t       ones
);
  state_t state, state_n;
  logic [7:0] sh;
  logic [11:0] bcd, adj;
  logic [3:0] cnt;
  function automatic bcd_t add3(input bcd_t n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
  assign adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign hund = bcd[11:8];
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      busy <= (state_n != IDLE);
    end
  always_comb
    case (state)
      IDLE:    state_n = load ? SHIFT : IDLE;
      SHIFT:   state_n = (cnt == 4'd7) ? DONE : SHIFT;
      default: state_n = IDLE;
    endcase
  always_comb done = (state == DONE);
  // Adjust-then-shift each SHIFT cycle; eight shifts leave the BCD result in bcd.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      bcd <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
    end else if (state == IDLE && load) begin
      sh <= bin;
      bcd <= '0;
      cnt <= '0;
      neg_q <= neg;
    end else if (state == SHIFT) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/ssd_sum_display.sv
// ssd_sum_display: 4-digit multiplexed common-anode display of a signed 8-bit sum (sign + 3 BCD digits).
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zeros of the hundreds and tens digits.
module ssd_sum_display
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int MAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] sum,
  input  logic             neg,
  input  logic             load,
  output logic             busy,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  logic done, c_neg, d_s, blank_h, blank_t;
  bcd_t c_h, c_t, c_o, d_h, d_t, d_o;
  logic [CW-1:0] rcnt;
  logic [1:0] idx;
  logic [6:0] seg_n;
  bin2bcd_seq u_conv (
    .clk(clk), .rst(rst), .load(load), .bin(sum), .neg(neg),
    .busy(busy), .done(done), .neg_q(c_neg), .hund(c_h), .tens(c_t), .ones(c_o)
  );
  // Display registers update atomically on completion, so no slot mixes old and new digits.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d_h <= '0;
      d_t <= '0;
      d_o <= '0;
      d_s <= 1'b0;
    end else if (done) begin
      d_h <= c_h;
      d_t <= c_t;
      d_o <= c_o;
      d_s <= c_neg && ({c_h, c_t, c_o} != 12'd0);
    end
`ifdef SSD_LEADING_ZERO_BLANK_EN
  assign blank_h = (d_h == 4'd0);
  assign blank_t = blank_h && (d_t == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif
  always_comb
    seg_n = (idx == 2'd3) ? (d_s ? SEG_MINUS : SEG_BLANK) :
            (idx == 2'd2) ? (blank_h ? SEG_BLANK : seg_decode(d_h)) :
            (idx == 2'd1) ? (blank_t ? SEG_BLANK : seg_decode(d_t)) :
            seg_decode(d_o);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rcnt <= '0;
      idx <= '0;
      an <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      rcnt <= (rcnt == LAST) ? '0 : rcnt + 1'b1;
      idx <= (rcnt == LAST) ? idx + 2'd1 : idx;
      an <= ~(4'b0001 << idx);
      seg <= seg_n;
    end
  assign dp = 1'b1;
endmodule
